tilemap_access_arbiter: RTL and testbench
=========================================

// Module: tilemap_access_arbiter
// PURPOSE
//  Shares the single-port tile-map RAM (11-bit addr, 6-bit tile index) between the VGA scanout
//  and the game-logic CPU port. Scanout reads have absolute priority, zero added latency.
//  CPU writes are buffered in a small FIFO. CPU writes and single reads use only slots the scanout leaves idle.
//  Sits between the VGA driver's tile-map address/data pins and the block RAM.
// PARAMETERS
//  AW          11  tile-map address width ({row[4:0],col[5:0]})
//  DW          6   tile index width
//  FIFO_DEPTH  4   CPU write FIFO entries; power of two, >=2
//  FIFO_AW     2   log2(FIFO_DEPTH)
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous, active-high reset
//  vga_rd        in   1    scanout owns RAM this cycle (high during active video)
//  vga_addr      in   AW   scanout address
//  vga_rdata     out  DW   = ram_rdata (combinational pass-through)
//  vblank        in   1    vertical blanking; only used with FRAME_SYNC_EN
//  wr_valid      in   1    CPU write request
//  wr_ready      out  1    FIFO not full
//  wr_addr       in   AW   CPU write address
//  wr_data       in   DW   CPU write data
//  rd_valid      in   1    CPU read request
//  rd_ready      out  1    read request accepted when valid&&ready
//  rd_addr       in   AW   CPU read address
//  rd_resp_valid out  1    one-cycle pulse, read data valid
//  rd_resp_data  out  DW   read data, held until next response
//  ram_addr      out  AW   RAM address (combinational mux)
//  ram_we        out  1    RAM write enable
//  ram_wdata     out  DW   RAM write data
//  ram_rdata     in   DW   RAM read data, synchronous read, 1-cycle latency
// BEHAVIOUR
//  - Reset: FIFO emptied, read-pending flag cleared, FSM=IDLE, rd_resp_valid=0, rd_resp_data=0.
//    A read in flight at reset produces no response. After reset: wr_ready=1, rd_ready=1.
//  - Mux: vga_rd=1 -> ram_addr=vga_addr, ram_we=0, regardless of FSM. Scanout is never delayed.
//  - Free slot = !vga_rd && gate. gate=1 without macro.
//  - Write accept: wr_valid&&wr_ready pushes {addr,data}. wr_ready=!full.
//    A push while full cannot occur. Push and pop in the same cycle keep the count unchanged.
//  - Read accept: rd_valid&&rd_ready latches rd_addr and sets pending.
//    rd_ready = !pending && state==IDLE, so at most one read is outstanding.
//  - FSM IDLE: on a free slot:
//      FIFO non-empty -> ram_addr=head.addr, ram_we=1, ram_wdata=head.data, pop; stay IDLE.
//      else pending -> ram_addr=latched addr, ram_we=0; go RD_WAIT.
//    Writes drain before a pending read, so a read observes all earlier-accepted writes.
//  - FSM RD_WAIT (1 cycle, unconditional): rd_resp_data<=ram_rdata, rd_resp_valid=1 next cycle;
//    clear pending; go IDLE. vga_rd in this cycle does not corrupt the capture
//    (ram_rdata reflects the previous address).
//  - Response latency: 2 cycles from the read issue slot; unbounded while vga_rd is held high.
//  - Address/data widths pass through unchanged; no arithmetic beyond FIFO pointers.
//    Pointers are FIFO_AW+1 bits with wrap bit; full/empty come from pointer compare.
// CONFIGURATION
//  FRAME_SYNC_EN defined: gate=vblank. CPU writes and reads are served only in vertical blanking
//    (tear-free updates). FIFO fills during active video; wr_ready drops after FIFO_DEPTH writes.
//  Undefined: gate=1. Horizontal-blanking slots are also used; vblank is ignored.
// STRUCTURE
//  Shared package vga_pkg: AW, DW, tile-map row/col field widths, FSM state encoding.
//  One sub-module, tilemap_wr_fifo: sync FIFO, push/pop/full/empty, first-word-fall-through head.
//  Arbiter FSM and mux stay in the top.
// TESTING
//  1 reset: rst 2 cycles -> wr_ready=1, rd_ready=1, rd_resp_valid=0, ram_we=0.
//  2 vga_rd=1 constant, push 4 writes -> ram_we stays 0, 5th cycle wr_ready=0.
//    Drop vga_rd -> 4 consecutive ram_we pulses, addresses in order.
//  3 write 0x123<=6'h2A, then read 0x123 with vga_rd=0 -> rd_resp_valid pulse, rd_resp_data=6'h2A.
//  4 read 0x010 with vga_rd toggling 1,0,1,1 -> exactly one response.
//    vga_addr always drives ram_addr when vga_rd=1.
//  5 push write, assert rst during pending read -> no rd_resp_valid, no ram_we after reset.
//  6 FRAME_SYNC_EN: vblank=0, vga_rd=0, push write -> no ram_we until vblank=1, then ram_we on the first vblank cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared tile-map constants, address helper and arbiter FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    // Tile-map address is {row[4:0], col[5:0]}
    localparam int ROW_W = 5;
    localparam int COL_W = 6;
    localparam int AW    = ROW_W + COL_W;
    localparam int DW    = 6;

    // Arbiter FSM states
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

    // Build a tile-map address from its row/column fields
    function automatic logic [AW-1:0] tile_addr(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/tilemap_wr_fifo.sv
// Synchronous FIFO with first-word-fall-through head for buffered CPU tile writes.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: full must gate push; pop only when !empty; push+pop together keep the level.
module tilemap_wr_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4,
    parameter int PAW   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [DEPTH];
    logic [PAW:0] wr_ptr;
    logic [PAW:0] rd_ptr;

    // Pointer advance; the extra MSB is the wrap bit that separates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PAW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PAW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PAW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[PAW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PAW] != rd_ptr[PAW]) &&
                      (wr_ptr[PAW-1:0] == rd_ptr[PAW-1:0]);

endmodule

// File: rtl/tilemap_access_arbiter.sv
// Shares the tile-map RAM between VGA scanout (absolute priority) and CPU writes/reads; build macro FRAME_SYNC_EN limits CPU access to vblank.
// Latency: scanout zero added; CPU read response 2 cycles after its issue slot; writes drain in free slots.
// Backpressure: wr_ready drops when the write FIFO is full; rd_ready low while a read is outstanding.
module tilemap_access_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_rd,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_rdata,
    input  logic          vblank,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_resp_valid,
    output logic [DW-1:0] rd_resp_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    import vga_pkg::*;

    logic                 gate;
    logic                 free;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [AW+DW-1:0]     head;
    logic [0:0]           state;
    logic                 pending;
    logic [AW-1:0]        rd_addr_q;

`ifdef FRAME_SYNC_EN
    // Tear-free mode: CPU traffic only touches the map during vertical blanking
    assign gate = vblank;
`else
    // Any slot the scanout leaves idle is usable; vblank is not needed
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate          = 1'b1;
`endif

    // A CPU slot exists only when scanout is idle; reset also blocks RAM writes
    assign free     = !vga_rd && gate && !rst;
    assign wr_ready = !fifo_full;
    assign push     = wr_valid && !fifo_full;
    assign rd_ready = !pending && (state == ST_IDLE);
    // Writes drain ahead of a pending read so the read sees every earlier write
    assign pop      = (state == ST_IDLE) && free && !fifo_empty;
    assign issue    = (state == ST_IDLE) && free && fifo_empty && pending;

    assign vga_rdata = ram_rdata;

    tilemap_wr_fifo #(
        .W     (AW + DW),
        .DEPTH (FIFO_DEPTH),
        .PAW   (FIFO_AW)
    ) u_wr_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({wr_addr, wr_data}),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // RAM port mux: scanout address by default, CPU write or read only in a free slot
    always_comb begin
        ram_addr  = vga_addr;
        ram_we    = 1'b0;
        ram_wdata = head[DW-1:0];
        if (pop) begin
            ram_addr = head[AW+DW-1:DW];
            ram_we   = 1'b1;
        end else if (issue) begin
            ram_addr = rd_addr_q;
        end
    end

    // Latch the accepted CPU read address
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else if (rd_valid && rd_ready) begin
            rd_addr_q <= rd_addr;
        end
    end

    // Arbiter FSM: issue a read from IDLE, capture its data in RD_WAIT, pulse the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pending       <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
        end else begin
            rd_resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) state <= ST_RD_WAIT;
                end
                default: begin
                    // ram_rdata belongs to the address issued last cycle, even if scanout owns the port now
                    rd_resp_data  <= ram_rdata;
                    rd_resp_valid <= 1'b1;
                    pending       <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
            if (rd_valid && rd_ready) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tilemap_access_arbiter.sv
// Randomized bench for tilemap_access_arbiter against a queue-based reference model.
// Latency: checks every cycle at negedge+1; RAM model updates at posedge+1.
// Backpressure: model predicts wr_ready/rd_ready from its own queue and read state.
module tb_tilemap_access_arbiter;
    import vga_pkg::*;

`ifdef FRAME_SYNC_EN
    localparam bit FRAME_SYNC = 1'b1;
`else
    localparam bit FRAME_SYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vga_rd, vblank, wr_valid, rd_valid;
    logic [10:0] vga_addr, wr_addr, rd_addr, ram_addr;
    logic [5:0]  wr_data, vga_rdata, rd_resp_data, ram_wdata, ram_rdata;
    logic        wr_ready, rd_ready, rd_resp_valid, ram_we;

    tilemap_access_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .vga_rd        (vga_rd),
        .vga_addr      (vga_addr),
        .vga_rdata     (vga_rdata),
        .vblank        (vblank),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Environment RAM (driven by DUT outputs) and the model's own view of the map
    logic [5:0]  ram_mem [2048];
    logic [5:0]  ref_mem [2048];

    // Reference model: pending writes in order, one outstanding read
    logic [16:0] m_wq [$];
    bit          m_pend, m_wait, m_resp_vld;
    logic [10:0] m_raddr;
    logic [5:0]  m_issue_dat, m_resp_dat;

    bit          chk_en;
    int          we_seen, resp_seen;
    logic [5:0]  last_resp;

    task automatic tick();
        bit          free, exp_pop, exp_issue, exp_wr_ready, exp_rd_ready;
        logic [16:0] head;
        logic [10:0] s_addr;
        logic        s_we;
        logic [5:0]  s_wdata;
        @(negedge clk);
        #1;
        head         = (m_wq.size() > 0) ? m_wq[0] : 17'd0;
        exp_wr_ready = (m_wq.size() < 4);
        exp_rd_ready = !m_pend && !m_wait;
        free         = !vga_rd && !rst && (FRAME_SYNC ? vblank : 1'b1);
        exp_pop      = free && !m_wait && (m_wq.size() > 0);
        exp_issue    = free && !m_wait && (m_wq.size() == 0) && m_pend;
        if (chk_en) begin
            check("wr_ready", wr_ready, exp_wr_ready);
            check("rd_ready", rd_ready, exp_rd_ready);
            check("resp_valid", rd_resp_valid, m_resp_vld);
            check("resp_data", rd_resp_data, m_resp_dat);
            check("ram_we", ram_we, exp_pop);
            check("vga_rdata", vga_rdata, ram_rdata);
            if (vga_rd) begin
                check("scan_addr", ram_addr, vga_addr);
            end else if (exp_pop) begin
                check("wr_addr_out", ram_addr, head[16:6]);
                check("wr_data_out", ram_wdata, head[5:0]);
            end else if (exp_issue) begin
                check("rd_addr_out", ram_addr, m_raddr);
            end
        end
        if (ram_we === 1'b1) we_seen++;
        if (rd_resp_valid === 1'b1) begin
            resp_seen++;
            last_resp = rd_resp_data;
        end
        s_addr  = ram_addr;
        s_we    = ram_we;
        s_wdata = ram_wdata;
        // Model next state
        if (rst) begin
            m_wq.delete();
            m_pend     = 1'b0;
            m_wait     = 1'b0;
            m_resp_vld = 1'b0;
            m_resp_dat = '0;
        end else begin
            m_resp_vld = m_wait;
            if (m_wait) begin
                m_resp_dat = m_issue_dat;
                m_pend     = 1'b0;
                m_wait     = 1'b0;
            end else if (exp_pop) begin
                ref_mem[head[16:6]] = head[5:0];
                void'(m_wq.pop_front());
            end else if (exp_issue) begin
                m_issue_dat = ref_mem[m_raddr];
                m_wait      = 1'b1;
            end
            if (wr_valid && exp_wr_ready) m_wq.push_back({wr_addr, wr_data});
            if (rd_valid && exp_rd_ready) begin
                m_pend  = 1'b1;
                m_raddr = rd_addr;
            end
        end
        @(posedge clk);
        #1;
        // Synchronous read-first RAM
        ram_rdata = ram_mem[s_addr];
        if (s_we === 1'b1) ram_mem[s_addr] = s_wdata;
    endtask

    initial begin
        logic [5:0] v;
        for (int i = 0; i < 2048; i++) begin
            v          = 6'($urandom);
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        ram_rdata = '0;
        rst = 1'b1; vga_rd = 1'b0; vblank = 1'b0; vga_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0;
        m_pend = 1'b0; m_wait = 1'b0; m_resp_vld = 1'b0; m_resp_dat = '0;
        m_raddr = '0; m_issue_dat = '0; last_resp = '0;
        we_seen = 0; resp_seen = 0;

        // 1: reset
        chk_en = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_ready", rd_ready, 1);
        check("rst_resp_valid", rd_resp_valid, 0);
        check("rst_ram_we", ram_we, 0);

        // 2: scanout holds the RAM while the FIFO fills, then drains in order
        vga_rd = 1'b1;
        wr_valid = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            vga_addr = 11'($urandom);
            wr_addr  = tile_addr(5'(i + 1), 6'(i * 3));
            wr_data  = 6'(8 + i);
            tick();
        end
        check("full_wr_ready", wr_ready, 0);
        tick();
        wr_valid = 1'b0;
        check("scan_no_we", we_seen, 0);
        vga_rd = 1'b0;
        vblank = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drain_we_cnt", we_seen, 4);

        // 3: write then read-back of the same address
        wr_valid = 1'b1; wr_addr = 11'h123; wr_data = 6'h2A;
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 11'h123;
        resp_seen = 0;
        tick();
        rd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rdback_cnt", resp_seen, 1);
        check("rdback_data", last_resp, 6'h2A);

        // 4: read while scanout toggles
        rd_valid = 1'b1; rd_addr = 11'h010;
        resp_seen = 0;
        tick();
        rd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vga_rd   = (i == 0 || i == 2 || i == 3);
            vga_addr = 11'($urandom);
            tick();
        end
        check("toggle_resp_cnt", resp_seen, 1);

        // 5a: reset with a buffered write and a pending, not yet issued read
        vga_rd = 1'b1;
        wr_valid = 1'b1; wr_addr = 11'h055; wr_data = 6'h11;
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 11'h055;
        tick();
        rd_valid = 1'b0;
        we_seen = 0; resp_seen = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vga_rd = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rst_pend_we", we_seen, 0);
        check("rst_pend_resp", resp_seen, 0);

        // 5b: reset while the read is in its capture cycle
        rd_valid = 1'b1; rd_addr = 11'h077;
        tick();
        rd_valid = 1'b0;
        tick();
        resp_seen = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst_flight_resp", resp_seen, 0);

`ifdef FRAME_SYNC_EN
        // 6: writes wait for vertical blanking
        vblank = 1'b0; vga_rd = 1'b0;
        wr_valid = 1'b1; wr_addr = 11'h200; wr_data = 6'h3C;
        tick();
        wr_valid = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 3; i++) tick();
        check("fs_no_we", we_seen, 0);
        vblank = 1'b1;
        tick();
        check("fs_first_vblank_we", we_seen, 1);
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            vga_rd   = ($urandom_range(0, 99) < 55);
            vga_addr = 11'($urandom);
            vblank   = ($urandom_range(0, 1) == 1);
            wr_valid = ($urandom_range(0, 99) < 40);
            wr_addr  = tile_addr(5'($urandom_range(0, 3)), 6'($urandom_range(0, 7)));
            wr_data  = 6'($urandom);
            rd_valid = ($urandom_range(0, 99) < 30);
            rd_addr  = tile_addr(5'($urandom_range(0, 3)), 6'($urandom_range(0, 7)));
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
